hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Sits beside the IF/ID and DEC/EX pipeline registers. Each cycle it decides whether the front end advances, stalls or flushes, and whether a NOP bubble is loaded into DEC/EX. It covers load-use hazards, taken branch/jump redirects from EX, and multi-cycle mult/div occupancy of the Hi/Lo unit, which it tracks with its own state machine. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/muldiv_busy_timer.sv | 62 ++++++
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: the Hi/Lo
// occupancy state encoding, the hard-wired zero register and default widths.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         STALL_CNT_W  = 16;
    localparam int         MULDIV_CNT_W = 4;

endpackage

// File: rtl/muldiv_busy_timer.sv
// Tracks how long the Hi/Lo unit stays occupied after a mult/div issues.
// A loadable down-counter drives a two-state IDLE/BUSY machine; busy is
// high for exactly MULDIV_CYCLES cycles following the issuing edge.
module muldiv_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic start,
    output logic busy
);

    localparam logic [MULDIV_CNT_W-1:0] LOAD_VAL = MULDIV_CNT_W'(MULDIV_CYCLES);
    localparam logic [MULDIV_CNT_W-1:0] ONE      = MULDIV_CNT_W'(1);

    md_state_t                 state;
    md_state_t                 state_nxt;
    logic [MULDIV_CNT_W-1:0]   cnt;
    logic [MULDIV_CNT_W-1:0]   cnt_nxt;

    // State and remaining-cycle registers; reset aborts any running operation.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: load on start, count down while busy, drop at one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = LOAD_VAL;
                end
            end
            ST_BUSY: begin
                if (cnt == ONE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Front-end hazard controller for the five-stage core. Every cycle it picks
// one of redirect (flush IF/ID, bubble DEC/EX), stall (freeze PC and IF/ID,
// bubble DEC/EX) or run. Load-use and Hi/Lo occupancy cause stalls; taken
// branches and jumps in EX cause redirects and win over any stall.
// Stall cycles are counted in a saturating performance counter.
//
// Handshake: there is no valid/ready pair here. PCWriteOut/IfIdWriteOut act
// as the "ready" of the front end: when low, the instruction in ID is held
// and must be presented again next cycle; DecExBubbleOut marks that the
// instruction entering EX this cycle is not valid.
module hazard_stall_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int STALL_CNT_W   = pipe_ctrl_pkg::STALL_CNT_W
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [4:0]             IdRsIn,
    input  logic [4:0]             IdRtIn,
    input  logic                   IdUsesRtIn,
    input  logic                   IdHiLoReadIn,
    input  logic                   IdMulDivIn,
    input  logic                   ExMemReadIn,
    input  logic                   ExRegWriteIn,
    input  logic [4:0]             ExRegDstIn,
    input  logic                   ExBranchTakenIn,
    input  logic                   ExJumpIn,
    output logic                   PCWriteOut,
    output logic                   IfIdWriteOut,
    output logic                   IfIdFlushOut,
    output logic                   DecExBubbleOut,
    output logic                   MulDivBusyOut,
    output logic [STALL_CNT_W-1:0] StallCntOut
);

    import pipe_ctrl_pkg::*;

    logic redirect;
    logic load_use;
    logic md_haz;
    logic stall;
    logic md_start;
    logic md_busy;

    logic [STALL_CNT_W-1:0] stall_cnt;

    // Hazard detection; a redirect squashes the ID instruction so its
    // hazards no longer matter.
    always_comb begin
        redirect = ExBranchTakenIn | ExJumpIn;
        load_use = ExMemReadIn & ExRegWriteIn & (ExRegDstIn != REG_ZERO) &
                   ((ExRegDstIn == IdRsIn) | (IdUsesRtIn & (ExRegDstIn == IdRtIn)));
        md_haz   = md_busy & (IdHiLoReadIn | IdMulDivIn);
        stall    = !redirect & (load_use | md_haz);
        // Only a mult/div that actually leaves ID may start the busy timer.
        md_start = IdMulDivIn & !redirect & !stall & !Rst;
    end

    // Pipeline-register controls with priority reset > redirect > stall > run.
    always_comb begin
        PCWriteOut     = 1'b1;
        IfIdWriteOut   = 1'b1;
        IfIdFlushOut   = 1'b0;
        DecExBubbleOut = 1'b0;
        if (Rst) begin
            PCWriteOut     = 1'b0;
            IfIdWriteOut   = 1'b0;
            IfIdFlushOut   = 1'b1;
            DecExBubbleOut = 1'b1;
        end else if (redirect) begin
            IfIdFlushOut   = 1'b1;
            DecExBubbleOut = 1'b1;
        end else if (stall) begin
            PCWriteOut     = 1'b0;
            IfIdWriteOut   = 1'b0;
            DecExBubbleOut = 1'b1;
        end
    end

    muldiv_busy_timer #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_muldiv_busy_timer (
        .Clk  (Clk),
        .Rst  (Rst),
        .start(md_start),
        .busy (md_busy)
    );

    // Saturating count of stall cycles; redirect cycles are not stalls.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign MulDivBusyOut = md_busy;
    assign StallCntOut   = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. A second instance with a 4-bit
// stall counter shares all inputs so saturation is visible alongside the
// full-width counter.
module tb_hazard_stall_ctrl;

    localparam int W = 30;

    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_REDIR = 4'b1111;
    localparam logic [3:0] C_RST   = 4'b0011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs, id_rt, ex_reg_dst;
    logic        id_uses_rt, id_hilo_read, id_muldiv;
    logic        ex_mem_read, ex_reg_write, ex_branch_taken, ex_jump;

    logic        pc_write, ifid_write, ifid_flush, decex_bubble, md_busy;
    logic [15:0] stall_cnt;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_decex_bubble, s_md_busy;
    logic [3:0]  s_stall_cnt;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULDIV_CYCLES(4), .STALL_CNT_W(16)) dut (
        .Clk(clk), .Rst(rst),
        .IdRsIn(id_rs), .IdRtIn(id_rt), .IdUsesRtIn(id_uses_rt),
        .IdHiLoReadIn(id_hilo_read), .IdMulDivIn(id_muldiv),
        .ExMemReadIn(ex_mem_read), .ExRegWriteIn(ex_reg_write),
        .ExRegDstIn(ex_reg_dst), .ExBranchTakenIn(ex_branch_taken), .ExJumpIn(ex_jump),
        .PCWriteOut(pc_write), .IfIdWriteOut(ifid_write), .IfIdFlushOut(ifid_flush),
        .DecExBubbleOut(decex_bubble), .MulDivBusyOut(md_busy), .StallCntOut(stall_cnt)
    );

    hazard_stall_ctrl #(.MULDIV_CYCLES(4), .STALL_CNT_W(4)) dut_sat (
        .Clk(clk), .Rst(rst),
        .IdRsIn(id_rs), .IdRtIn(id_rt), .IdUsesRtIn(id_uses_rt),
        .IdHiLoReadIn(id_hilo_read), .IdMulDivIn(id_muldiv),
        .ExMemReadIn(ex_mem_read), .ExRegWriteIn(ex_reg_write),
        .ExRegDstIn(ex_reg_dst), .ExBranchTakenIn(ex_branch_taken), .ExJumpIn(ex_jump),
        .PCWriteOut(s_pc_write), .IfIdWriteOut(s_ifid_write), .IfIdFlushOut(s_ifid_flush),
        .DecExBubbleOut(s_decex_bubble), .MulDivBusyOut(s_md_busy), .StallCntOut(s_stall_cnt)
    );

    // driver tasks
    task automatic quiet();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_hilo_read = 1'b0; id_muldiv = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_reg_dst = 5'd0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0;
    endtask

    task automatic randomize_inputs();
        id_rs = 5'($urandom_range(0, 31)); id_rt = 5'($urandom_range(0, 31));
        id_uses_rt = 1'($urandom_range(0, 1)); id_hilo_read = 1'($urandom_range(0, 1));
        id_muldiv = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
        ex_reg_write = 1'($urandom_range(0, 1)); ex_reg_dst = 5'($urandom_range(0, 31));
        ex_branch_taken = 1'($urandom_range(0, 1)); ex_jump = 1'($urandom_range(0, 1));
    endtask

    task automatic load_in_ex(input logic [4:0] dst);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_reg_dst = dst;
    endtask

    // scoreboard: push the expectation for the driven inputs, then compare
    // once the combinational outputs have settled (well before the edge).
    task automatic check(input string tag, input logic [3:0] ctrl,
                         input logic busy, input logic [15:0] sc);
        logic [3:0]   sat;
        logic [W-1:0] obs;
        logic [W-1:0] exp_v;
        sat = (sc > 16'd15) ? 4'd15 : sc[3:0];
        exp_q.push_back({ctrl, busy, sc, ctrl, busy, sat});
        #2;
        obs = {pc_write, ifid_write, ifid_flush, decex_bubble, md_busy, stall_cnt,
               s_pc_write, s_ifid_write, s_ifid_flush, s_decex_bubble, s_md_busy, s_stall_cnt};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        quiet();
        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); randomize_inputs();
            check("reset_hold", C_RST, 1'b0, 16'd0);
        end
        @(negedge clk); rst = 1'b0; quiet();
        check("reset_release_run", C_RUN, 1'b0, 16'd0);

        // load-use on rs: exactly one stall cycle
        @(negedge clk); quiet(); load_in_ex(5'd8); id_rs = 5'd8;
        check("load_use_rs_stall", C_STALL, 1'b0, 16'd0);
        @(negedge clk); quiet();
        check("load_use_released", C_RUN, 1'b0, 16'd1);

        // no false hazards
        @(negedge clk); quiet(); load_in_ex(5'd0); id_rs = 5'd0;
        check("dst_zero_no_stall", C_RUN, 1'b0, 16'd1);
        @(negedge clk); quiet(); load_in_ex(5'd9); id_rt = 5'd9; id_rs = 5'd3;
        check("rt_unused_no_stall", C_RUN, 1'b0, 16'd1);
        @(negedge clk); id_uses_rt = 1'b1;
        check("load_use_rt_stall", C_STALL, 1'b0, 16'd1);
        @(negedge clk); quiet(); load_in_ex(5'd9); id_rs = 5'd9; ex_reg_write = 1'b0;
        check("no_regwrite_no_stall", C_RUN, 1'b0, 16'd2);

        // mult issues, then mfhi waits four busy cycles
        @(negedge clk); quiet(); id_muldiv = 1'b1;
        check("mult_issue", C_RUN, 1'b0, 16'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); quiet(); id_hilo_read = 1'b1;
            check("mfhi_busy_stall", C_STALL, 1'b1, 16'(2 + i));
        end
        @(negedge clk);
        check("mfhi_released", C_RUN, 1'b0, 16'd6);
        @(negedge clk); quiet();
        check("after_mfhi_run", C_RUN, 1'b0, 16'd6);

        // redirect beats a coincident load-use stall
        @(negedge clk); quiet(); load_in_ex(5'd4); id_rs = 5'd4; ex_branch_taken = 1'b1;
        check("redirect_over_stall", C_REDIR, 1'b0, 16'd6);
        @(negedge clk); quiet();
        check("redirect_not_counted", C_RUN, 1'b0, 16'd6);

        // redirect in BUSY does not disturb the remaining count
        @(negedge clk); quiet(); id_muldiv = 1'b1;
        check("mult_issue_2", C_RUN, 1'b0, 16'd6);
        @(negedge clk); quiet(); ex_jump = 1'b1; id_hilo_read = 1'b1;
        check("jump_during_busy", C_REDIR, 1'b1, 16'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); quiet(); id_hilo_read = 1'b1;
            check("busy_after_jump", C_STALL, 1'b1, 16'(6 + i));
        end
        @(negedge clk);
        check("busy_done_after_jump", C_RUN, 1'b0, 16'd9);

        // a mult/div squashed by redirect or held by stall does not start
        @(negedge clk); quiet(); id_muldiv = 1'b1; ex_branch_taken = 1'b1;
        check("mult_squashed", C_REDIR, 1'b0, 16'd9);
        @(negedge clk); quiet();
        check("no_busy_after_squash", C_RUN, 1'b0, 16'd9);
        @(negedge clk); quiet(); id_muldiv = 1'b1; load_in_ex(5'd5); id_rs = 5'd5;
        check("mult_held_by_stall", C_STALL, 1'b0, 16'd9);
        @(negedge clk); quiet();
        check("no_busy_after_stall", C_RUN, 1'b0, 16'd10);

        // 20 stall cycles: narrow counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); quiet(); load_in_ex(5'd7); id_rs = 5'd7;
            check("saturation_stall", C_STALL, 1'b0, 16'(10 + i));
        end
        @(negedge clk); quiet();
        check("saturation_hold", C_RUN, 1'b0, 16'd30);

        // reset pulsed mid-BUSY aborts immediately
        @(negedge clk); quiet(); id_muldiv = 1'b1;
        check("mult_issue_3", C_RUN, 1'b0, 16'd30);
        @(negedge clk); quiet();
        check("busy_before_abort", C_RUN, 1'b1, 16'd30);
        @(negedge clk); rst = 1'b1;
        check("reset_abort", C_RST, 1'b0, 16'd0);
        @(negedge clk); rst = 1'b0; id_hilo_read = 1'b1;
        check("mfhi_after_abort", C_RUN, 1'b0, 16'd0);

        // final report
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
